hazard_stall_ctrl: RTL

// - Generates the pipeline-register control signals: PCWrite, IFDWrite and IF_Flush
//   for the IF/ID register, and ID_Flush for ID/EX bubble insertion.
// - Detects load-use hazards, ID-stage taken branches/jumps and multi-cycle data-memory stalls.
// - Sequences multi-cycle bubbles and memory waits with a small FSM.
// - Sits in the ID stage, beside the register file. Drives the PC, the IF/ID stage and the ID/EX stage.

---
 rtl/hazard_stall_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard/stall controller: load-use bubbles, branch/jump IF flush, data-memory wait freeze.
// Optional HAZARD_STATS_EN adds saturating StallCount/FlushCount outputs.
module hazard_stall_ctrl #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned LU_BUBBLES = 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_Rt,
    input  logic             ID_BranchTaken,
    input  logic             ID_Jump,
    input  logic             MEM_Busy,
    output logic             PCWrite,
    output logic             IFDWrite,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             EXMWrite
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      StallCount,
    output logic [15:0]      FlushCount
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_BUBBLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_lu_hazard;
    logic w_redirect;
    logic w_pc_write;
    logic w_ifd_write;
    logic w_if_flush;
    logic w_id_flush;
    logic w_exm_write;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency
    assign w_lu_hazard = EX_MemRead && (EX_Rt != '0) &&
                         ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
    assign w_redirect  = ID_BranchTaken || ID_Jump;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Priority: memory wait freezes everything, then bubbles, then redirect flush
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_write  = 1'b1;
        w_ifd_write = 1'b1;
        w_if_flush  = 1'b0;
        w_id_flush  = 1'b0;
        w_exm_write = 1'b1;

        if (MEM_Busy) begin
            w_pc_write  = 1'b0;
            w_ifd_write = 1'b0;
            w_exm_write = 1'b0;
            w_state_nxt = ST_MEM_WAIT;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_lu_hazard) begin
                        w_pc_write  = 1'b0;
                        w_ifd_write = 1'b0;
                        w_id_flush  = 1'b1;
                        if (LU_BUBBLES > 1) begin
                            w_state_nxt = ST_BUBBLE;
                            w_cnt_nxt   = LU_RELOAD;
                        end
                    end else if (w_redirect) begin
                        w_if_flush = 1'b1;
                    end
                end
                ST_BUBBLE: begin
                    w_pc_write  = 1'b0;
                    w_ifd_write = 1'b0;
                    w_id_flush  = 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    w_state_nxt = (r_cnt != '0) ? ST_BUBBLE : ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // While held in reset the pipe is frozen and both stage registers are flushed
        if (!Reset_n) begin
            w_pc_write  = 1'b0;
            w_ifd_write = 1'b0;
            w_if_flush  = 1'b1;
            w_id_flush  = 1'b1;
            w_exm_write = 1'b0;
        end
    end

    assign PCWrite  = w_pc_write;
    assign IFDWrite = w_ifd_write;
    assign IF_Flush = w_if_flush;
    assign ID_Flush = w_id_flush;
    assign EXMWrite = w_exm_write;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating event counters for performance monitoring
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_if_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;
`endif

endmodule
